// File: rtl/sdram_stream_arbiter.sv
// Shares one SDRAM Avalon-MM slave between the video frame reader (priority) and the PCIe DMA master.
// Bounded PCIe starvation; returning read beats are routed by an outstanding-burst tag FIFO.
module sdram_stream_arbiter #(
  parameter int ADDR_W     = 27,
  parameter int VID_BURST  = 8,
  parameter int STARVE_MAX = 4,
  parameter int MAX_PEND   = 4
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [ADDR_W-1:0] v_address,
  input  logic              v_read,
  output logic              v_waitrequest,
  output logic              v_readdatavalid,
  input  logic [ADDR_W-1:0] p_address,
  input  logic              p_read,
  input  logic              p_write,
  input  logic [31:0]       p_writedata,
  input  logic [3:0]        p_byteenable,
  input  logic [3:0]        p_burstcount,
  output logic              p_waitrequest,
  output logic              p_readdatavalid,
  output logic [31:0]       m_readdata,
  output logic [ADDR_W-1:0] s_address,
  output logic              s_read,
  output logic              s_write,
  output logic [31:0]       s_writedata,
  output logic [3:0]        s_byteenable,
  output logic [3:0]        s_burstcount,
  input  logic              s_waitrequest,
  input  logic [31:0]       s_readdata,
  input  logic              s_readdatavalid
);
  localparam int PW = (MAX_PEND > 1) ? $clog2(MAX_PEND) : 1;
  localparam int CW = $clog2(MAX_PEND + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [3:0] VB = 4'(VID_BURST);

  typedef enum logic [1:0] {IDLE, V_CMD, P_RD, P_WR} state_t;

  state_t          state;
  logic [SW-1:0]   starve_cnt;
  logic            wr_started;
  logic [3:0]      wr_burst;
  logic [3:0]      wr_left;
  logic [4:0]      tag_mem [MAX_PEND];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   pend_cnt;
  logic [3:0]      beat_cnt;

  logic       pend_ok, v_go, p_go_rd, p_go_wr, p_wins;
  logic [3:0] p_burst_n;
  logic       push, push_tag, pop, rd_beat, head_tag;
  logic [3:0] push_burst, head_burst;

  assign p_burst_n  = (p_burstcount == 4'd0) ? 4'd1 : p_burstcount;
  assign pend_ok    = pend_cnt < CW'(MAX_PEND);
  assign v_go       = v_read && pend_ok;
  assign p_go_rd    = p_read && pend_ok;
  assign p_go_wr    = p_write;
  assign p_wins     = (p_go_rd || p_go_wr) && (!v_go || starve_cnt >= SW'(STARVE_MAX));

  assign push       = !s_waitrequest && ((state == V_CMD && v_read) || (state == P_RD && p_read));
  assign push_tag   = (state == P_RD);
  assign push_burst = (state == P_RD) ? p_burst_n : VB;
  assign head_tag   = tag_mem[rd_ptr][4];
  assign head_burst = tag_mem[rd_ptr][3:0];
  // Beats with nothing outstanding (or during reset) are dropped silently.
  assign rd_beat    = s_readdatavalid && (pend_cnt != '0) && !reset_reset;
  assign pop        = rd_beat && (beat_cnt == head_burst - 4'd1);

  assign v_readdatavalid = rd_beat && !head_tag;
  assign p_readdatavalid = rd_beat && head_tag;
  assign m_readdata      = s_readdata;

  always_comb begin
    s_address     = '0;
    s_read        = 1'b0;
    s_write       = 1'b0;
    s_writedata   = '0;
    s_byteenable  = '0;
    s_burstcount  = '0;
    v_waitrequest = 1'b1;
    p_waitrequest = 1'b1;
    case (state)
      V_CMD: begin
        s_address     = v_address;
        s_read        = v_read;
        s_burstcount  = VB;
        v_waitrequest = s_waitrequest;
      end
      P_RD: begin
        s_address     = p_address;
        s_read        = p_read;
        s_burstcount  = p_burst_n;
        p_waitrequest = s_waitrequest;
      end
      P_WR: begin
        s_address     = p_address;
        s_write       = p_write;
        s_writedata   = p_writedata;
        s_byteenable  = p_byteenable;
        s_burstcount  = wr_started ? wr_burst : p_burst_n;
        p_waitrequest = s_waitrequest;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      wr_started <= 1'b0;
      wr_burst   <= '0;
      wr_left    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      pend_cnt   <= '0;
      beat_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (p_wins) begin
            state      <= p_go_wr ? P_WR : P_RD;
            starve_cnt <= '0;
            wr_started <= 1'b0;
          end else if (v_go) begin
            state <= V_CMD;
            if ((p_read || p_write) && starve_cnt < SW'(STARVE_MAX))
              starve_cnt <= starve_cnt + 1'b1;
          end
        end
        V_CMD: if (!v_read || !s_waitrequest) state <= IDLE;
        P_RD:  if (!p_read || !s_waitrequest) state <= IDLE;
        P_WR: begin
          if (p_write && !s_waitrequest) begin
            if (!wr_started) begin
              if (p_burst_n == 4'd1) begin
                state <= IDLE;
              end else begin
                wr_started <= 1'b1;
                wr_burst   <= p_burst_n;
                wr_left    <= p_burst_n - 4'd1;
              end
            end else if (wr_left == 4'd1) begin
              state      <= IDLE;
              wr_started <= 1'b0;
            end else begin
              wr_left <= wr_left - 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (push) begin
        tag_mem[wr_ptr] <= {push_tag, push_burst};
        wr_ptr <= (wr_ptr == PW'(MAX_PEND - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr   <= (rd_ptr == PW'(MAX_PEND - 1)) ? '0 : rd_ptr + 1'b1;
        beat_cnt <= '0;
      end else if (rd_beat) begin
        beat_cnt <= beat_cnt + 4'd1;
      end
      if (push && !pop)      pend_cnt <= pend_cnt + 1'b1;
      else if (!push && pop) pend_cnt <= pend_cnt - 1'b1;
    end
  end
endmodule

// File: tb/tb_sdram_stream_arbiter.sv
// Bench for sdram_stream_arbiter: directed spec scenarios plus randomized traffic,
// with a burst-level ownership queue predicting where each returning beat goes.
module tb_sdram_stream_arbiter;
  logic        clk_clk = 1'b0;
  logic        reset_reset;
  logic [26:0] v_address, p_address, s_address;
  logic        v_read, v_waitrequest, v_readdatavalid;
  logic        p_read, p_write, p_waitrequest, p_readdatavalid;
  logic [31:0] p_writedata, m_readdata, s_writedata, s_readdata;
  logic [3:0]  p_byteenable, p_burstcount, s_byteenable, s_burstcount;
  logic        s_read, s_write, s_waitrequest, s_readdatavalid;

  int checks = 0;
  int errors = 0;
  bit owner_q[$];
  int left_q[$];

  always #5 clk_clk = ~clk_clk;

  sdram_stream_arbiter dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset),
    .v_address(v_address), .v_read(v_read), .v_waitrequest(v_waitrequest),
    .v_readdatavalid(v_readdatavalid),
    .p_address(p_address), .p_read(p_read), .p_write(p_write), .p_writedata(p_writedata),
    .p_byteenable(p_byteenable), .p_burstcount(p_burstcount), .p_waitrequest(p_waitrequest),
    .p_readdatavalid(p_readdatavalid), .m_readdata(m_readdata),
    .s_address(s_address), .s_read(s_read), .s_write(s_write), .s_writedata(s_writedata),
    .s_byteenable(s_byteenable), .s_burstcount(s_burstcount), .s_waitrequest(s_waitrequest),
    .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic int norm(input int b);
    return (b == 0) ? 1 : b;
  endfunction

  function automatic int beats_left();
    int s = 0;
    foreach (left_q[i]) s += left_q[i];
    return s;
  endfunction

  task automatic model_push(input bit m, input int n);
    owner_q.push_back(m);
    left_q.push_back(n);
  endtask

  // Deliver n return beats, optionally with idle gaps, checking routing against the model.
  task automatic read_beats(input int n, input bit gaps);
    bit ev, ep;
    logic [31:0] d;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_readdatavalid = 1'b0;
        settle();
        chk("gap_v_valid", v_readdatavalid, 0);
        chk("gap_p_valid", p_readdatavalid, 0);
        tick();
      end
      d = $urandom;
      s_readdatavalid = 1'b1;
      s_readdata = d;
      settle();
      ev = 0; ep = 0;
      if (owner_q.size() > 0) begin
        if (owner_q[0]) ep = 1; else ev = 1;
        left_q[0] = left_q[0] - 1;
        if (left_q[0] == 0) begin
          void'(owner_q.pop_front());
          void'(left_q.pop_front());
        end
      end
      chk("beat_v_valid", v_readdatavalid, ev);
      chk("beat_p_valid", p_readdatavalid, ep);
      chk("beat_data", m_readdata, d);
      tick();
      s_readdatavalid = 1'b0;
    end
  endtask

  // Single read command from one master, slave stalling randomly; FIFO must have room.
  task automatic do_read(input bit m, input logic [26:0] a, input int b);
    int sw;
    if (m) begin p_read = 1'b1; p_address = a; p_burstcount = 4'(b); end
    else begin v_read = 1'b1; v_address = a; end
    s_waitrequest = 1'b0;
    settle();
    chk("rd_arb_wait", m ? p_waitrequest : v_waitrequest, 1);
    tick();
    for (int k = 0; k < 20; k++) begin
      sw = (k >= 8) ? 0 : $urandom_range(0, 1);
      s_waitrequest = sw[0];
      settle();
      chk("rd_s_read", s_read, 1);
      chk("rd_s_addr", s_address, a);
      chk("rd_s_burst", s_burstcount, m ? norm(b) : 8);
      chk("rd_own_wait", m ? p_waitrequest : v_waitrequest, sw[0]);
      chk("rd_other_wait", m ? v_waitrequest : p_waitrequest, 1);
      tick();
      if (sw == 0) break;
    end
    v_read = 1'b0; p_read = 1'b0; s_waitrequest = 1'b0;
    model_push(m, m ? norm(b) : 8);
  endtask

  // PCIe write burst with random slave stalls, master gaps, and burstcount changed after the first beat.
  task automatic do_write(input logic [26:0] a, input int b);
    int nb, acc, sw, pw;
    logic [31:0] wd;
    logic [3:0] be;
    nb = norm(b); acc = 0;
    p_write = 1'b1; p_address = a; p_burstcount = 4'(b);
    wd = $urandom; be = 4'($urandom);
    p_writedata = wd; p_byteenable = be;
    s_waitrequest = 1'b0;
    settle();
    chk("wr_arb_wait", p_waitrequest, 1);
    tick();
    for (int k = 0; k < 60 && acc < nb; k++) begin
      sw = (k >= 40) ? 0 : $urandom_range(0, 1);
      pw = (acc == 0 || k >= 40) ? 1 : ($urandom_range(0, 3) != 0);
      p_write = pw[0];
      s_waitrequest = sw[0];
      if (acc > 0) p_burstcount = 4'($urandom);
      settle();
      chk("wr_s_write", s_write, pw[0]);
      chk("wr_p_wait", p_waitrequest, sw[0]);
      chk("wr_v_wait", v_waitrequest, 1);
      chk("wr_s_burst", s_burstcount, nb);
      chk("wr_s_addr", s_address, a);
      if (pw != 0) begin
        chk("wr_s_data", s_writedata, wd);
        chk("wr_s_be", s_byteenable, be);
      end
      tick();
      if (pw != 0 && sw == 0) begin
        acc++;
        wd = $urandom; be = 4'($urandom);
        p_writedata = wd; p_byteenable = be;
      end
    end
    chk("wr_beats", acc, nb);
    p_write = 1'b0; s_waitrequest = 1'b0;
    settle();
    chk("wr_end_p_wait", p_waitrequest, 1);
    chk("wr_end_s_write", s_write, 0);
    tick();
  endtask

  initial begin
    bit grants[$];
    logic [31:0] wdat [4];
    int beat, tgl, hl, r;
    logic [26:0] xa;

    reset_reset = 1'b1;
    v_address = '0; v_read = 1'b0; p_address = '0; p_read = 1'b0; p_write = 1'b0;
    p_writedata = '0; p_byteenable = '0; p_burstcount = '0;
    s_waitrequest = 1'b0; s_readdata = '0; s_readdatavalid = 1'b0;

    // Reset state
    tick(); tick();
    settle();
    chk("rst_s_read", s_read, 0);
    chk("rst_s_write", s_write, 0);
    chk("rst_v_wait", v_waitrequest, 1);
    chk("rst_p_wait", p_waitrequest, 1);
    chk("rst_v_valid", v_readdatavalid, 0);
    chk("rst_p_valid", p_readdatavalid, 0);
    reset_reset = 1'b0;
    tick();
    s_readdatavalid = 1'b1;
    settle();
    chk("stray_v_valid", v_readdatavalid, 0);
    chk("stray_p_valid", p_readdatavalid, 0);
    tick();
    s_readdatavalid = 1'b0;

    // Lone video read at 0x100, eight beats back to video
    v_read = 1'b1; v_address = 27'h100;
    settle();
    chk("v1_arb_wait", v_waitrequest, 1);
    tick();
    settle();
    chk("v1_s_read", s_read, 1);
    chk("v1_s_addr", s_address, 27'h100);
    chk("v1_s_burst", s_burstcount, 8);
    chk("v1_v_wait", v_waitrequest, 0);
    chk("v1_p_wait", p_waitrequest, 1);
    tick();
    v_read = 1'b0;
    model_push(0, 8);
    settle();
    chk("v1_idle_s_read", s_read, 0);
    tick();
    read_beats(8, 1'b0);

    // Video held + PCIe write burst 4 waiting: expect V,V,V,V,P
    v_read = 1'b1; v_address = 27'h2000;
    p_write = 1'b1; p_address = 27'h4440; p_burstcount = 4'd4; p_byteenable = 4'hF;
    for (int i = 0; i < 4; i++) wdat[i] = $urandom;
    p_writedata = wdat[0];
    s_waitrequest = 1'b0;
    for (int k = 0; k < 30 && grants.size() < 5; k++) begin
      tick();
      settle();
      if (!v_waitrequest) begin
        grants.push_back(1'b0);
        chk("sv_s_addr", s_address, 27'h2000);
      end
      if (!p_waitrequest) grants.push_back(1'b1);
      if (!p_waitrequest) break;
    end
    chk("starve_ngrants", grants.size(), 5);
    for (int i = 0; i < grants.size() && i < 5; i++)
      chk($sformatf("starve_grant%0d", i), grants[i], (i == 4));
    for (int i = 0; i < 4; i++) model_push(0, 8);
    beat = 0; tgl = 1;
    for (int k = 0; k < 20 && beat < 4; k++) begin
      s_waitrequest = tgl[0];
      p_writedata = wdat[beat];
      p_burstcount = (beat == 0) ? 4'd4 : 4'd0;
      settle();
      chk("sw_s_write", s_write, 1);
      chk("sw_p_wait", p_waitrequest, tgl[0]);
      chk("sw_v_wait", v_waitrequest, 1);
      chk("sw_s_data", s_writedata, wdat[beat]);
      chk("sw_s_burst", s_burstcount, 4);
      tick();
      if (tgl == 0) beat++;
      tgl = 1 - tgl;
    end
    chk("sw_beats", beat, 4);
    p_write = 1'b0; v_read = 1'b0; s_waitrequest = 1'b0;
    settle();
    chk("sw_end_p_wait", p_waitrequest, 1);
    chk("sw_end_s_write", s_write, 0);
    tick();
    read_beats(32, 1'b1);

    // Video burst 8 then PCIe burst 2 before any data: 8 beats video, 2 PCIe
    do_read(0, 27'h200, 8);
    do_read(1, 27'h300, 2);
    read_beats(10, 1'b0);
    chk("vp_drained", owner_q.size(), 0);

    // Four outstanding reads fill the FIFO; a fifth waits for the head to drain
    for (int i = 0; i < 4; i++)
      do_read($urandom_range(0, 1), 27'($urandom), $urandom_range(0, 8));
    xa = 27'($urandom);
    v_read = 1'b1; v_address = xa; s_waitrequest = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("full_v_wait", v_waitrequest, 1);
      chk("full_s_read", s_read, 0);
      tick();
    end
    hl = left_q[0];
    read_beats(hl, 1'b0);
    settle();
    chk("full_pop_v_wait", v_waitrequest, 1);
    tick();
    settle();
    chk("full_grant_v_wait", v_waitrequest, 0);
    chk("full_grant_s_read", s_read, 1);
    chk("full_grant_addr", s_address, xa);
    tick();
    v_read = 1'b0;
    model_push(0, 8);
    read_beats(beats_left(), 1'b1);

    // Randomized mix of reads, writes and return traffic
    for (int it = 0; it < 24; it++) begin
      r = $urandom_range(0, 3);
      if (r == 0) do_write(27'($urandom), $urandom_range(0, 8));
      else if (r == 3 || owner_q.size() >= 4) read_beats($urandom_range(1, 10), 1'b1);
      else do_read($urandom_range(0, 1), 27'($urandom), $urandom_range(0, 8));
    end
    read_beats(beats_left() + 1, 1'b1);

    // Reset in the middle of a write burst with a read outstanding
    do_read(0, 27'h5000, 8);
    p_write = 1'b1; p_address = 27'h6000; p_burstcount = 4'd4; p_writedata = $urandom;
    s_waitrequest = 1'b0;
    settle();
    tick();
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("rw_s_write", s_write, 1);
      tick();
    end
    reset_reset = 1'b1;
    settle();
    tick();
    settle();
    chk("rw_s_write_after", s_write, 0);
    chk("rw_s_read_after", s_read, 0);
    chk("rw_p_wait_after", p_waitrequest, 1);
    reset_reset = 1'b0; p_write = 1'b0;
    owner_q.delete(); left_q.delete();
    s_readdatavalid = 1'b1;
    settle();
    chk("rw_stray_v_valid", v_readdatavalid, 0);
    chk("rw_stray_p_valid", p_readdatavalid, 0);
    tick();
    s_readdatavalid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
